// File: rtl/bpm_estimator_if.sv
// Tempo-estimate bundle between the onset detector, the estimator and the threshold filter.
// bpm_valid is a one-cycle strobe with no back-pressure: the consumer must take bpm_estimate in that cycle.
interface bpm_estimator_if #(
  parameter int BW = 8
);
  logic          beat_in;
  logic [BW-1:0] bpm_estimate;
  logic          bpm_valid;
  logic          locked;
  logic          busy;
  logic [1:0]    state_dbg;

  modport master (
    output beat_in,
    input  bpm_estimate, bpm_valid, locked, busy, state_dbg
  );

  modport slave (
    input  beat_in,
    output bpm_estimate, bpm_valid, locked, busy, state_dbg
  );
endinterface

// File: rtl/bpm_estimator.sv
// Beat-interval tempo estimator: measures edge spacing, averages the last 2^AVG_LOG2
// accepted intervals and divides 60*CLK_HZ by the average with a restoring divider.
module bpm_estimator #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int MAX_BPM  = 200,
  parameter int MIN_BPM  = 40,
  parameter int AVG_LOG2 = 2
) (
  input  logic         clk,
  input  logic         reset,
  bpm_estimator_if.slave bus
);
  localparam int              DW      = 32;
  localparam int              BW      = $clog2(MAX_BPM + 1);
  localparam int              NH      = 1 << AVG_LOG2;
  localparam int              SW      = DW + AVG_LOG2;
  localparam int              IW      = $clog2(DW) + 1;
  localparam longint unsigned K_WIDE  = 64'(CLK_HZ) * 64'd60;
  localparam logic [DW-1:0]   K       = DW'(K_WIDE);
  localparam logic [DW-1:0]   MIN_INT = DW'(K_WIDE / 64'(MAX_BPM));
  localparam logic [DW-1:0]   MAX_INT = DW'(K_WIDE / 64'(MIN_BPM));
  localparam logic [DW-1:0]   CNT_SAT = MAX_INT + DW'(1);

  if ((MIN_INT <= DW'(2 * DW + 4)) || ((K_WIDE >> DW) != 64'd0)) begin : g_bad_params
    $error("bpm_estimator: MIN_INT too small for divider latency or 60*CLK_HZ exceeds 32 bits");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DIVIDE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          beat_q, beat_d;
  logic [DW-1:0] counter_q, counter_d;
  logic [DW-1:0] hist_q [NH];
  logic [DW-1:0] hist_d [NH];
  logic [SW-1:0] sum_q, sum_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic [BW-1:0] bpm_q, bpm_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;

  logic          beat_edge;
  logic          accept;
  logic [DW-1:0] cnt_inc;
  logic [DW:0]   rem_shift;
  logic [DW:0]   trial;
  logic [DW-1:0] rem_next;
  logic [DW-1:0] quot_next;
  logic [BW-1:0] bpm_clamped;

  always_comb begin
    state_d   = state_q;
    beat_d    = bus.beat_in;
    counter_d = counter_q;
    hist_d    = hist_q;
    sum_d     = sum_q;
    load_d    = 1'b0;
    busy_d    = busy_q;
    iter_d    = iter_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    bpm_d     = bpm_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    accept    = 1'b0;

    beat_edge = bus.beat_in & ~beat_q;
    cnt_inc   = (counter_q == CNT_SAT) ? counter_q : counter_q + DW'(1);

    // One restoring step: the dividend shifts out of quot_q MSB-first as quotient bits shift in.
    rem_shift = {rem_q, quot_q[DW-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    if (trial[DW]) begin
      rem_next  = rem_shift[DW-1:0];
      quot_next = {quot_q[DW-2:0], 1'b0};
    end else begin
      rem_next  = trial[DW-1:0];
      quot_next = {quot_q[DW-2:0], 1'b1};
    end

    if (quot_next < DW'(MIN_BPM))      bpm_clamped = BW'(MIN_BPM);
    else if (quot_next > DW'(MAX_BPM)) bpm_clamped = BW'(MAX_BPM);
    else                               bpm_clamped = quot_next[BW-1:0];

    case (state_q)
      IDLE: begin
        if (beat_edge) begin
          counter_d = DW'(1);
          state_d   = COUNT;
        end
      end
      COUNT: begin
        // Timeout beats a coincident edge; that edge then restarts measurement as a first beat.
        if (counter_q == CNT_SAT) begin
          for (int i = 0; i < NH; i++) hist_d[i] = '0;
          sum_d    = '0;
          locked_d = 1'b0;
          if (beat_edge) begin
            counter_d = DW'(1);
            state_d   = COUNT;
          end else begin
            counter_d = '0;
            state_d   = IDLE;
          end
        end else begin
          counter_d = cnt_inc;
          if (beat_edge && (counter_q >= MIN_INT)) accept = 1'b1;
        end
      end
      DIVIDE: begin
        counter_d = cnt_inc;
        if (load_q) begin
          rem_d     = '0;
          quot_d    = K;
          divisor_d = sum_q[SW-1:AVG_LOG2];
          iter_d    = IW'(DW);
          busy_d    = 1'b1;
        end else if (busy_q) begin
          rem_d  = rem_next;
          quot_d = quot_next;
          iter_d = iter_q - IW'(1);
          if (iter_q == IW'(1)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
            bpm_d   = bpm_clamped;
            state_d = COUNT;
          end
        end else begin
          state_d = COUNT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      counter_d = DW'(1);
      state_d   = DIVIDE;
      load_d    = 1'b1;
      locked_d  = 1'b1;
      if (!locked_q) begin
        for (int i = 0; i < NH; i++) hist_d[i] = counter_q;
        sum_d = SW'(counter_q) << AVG_LOG2;
      end else begin
        sum_d     = sum_q - SW'(hist_q[NH-1]) + SW'(counter_q);
        hist_d[0] = counter_q;
        for (int i = 1; i < NH; i++) hist_d[i] = hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= 1'b0;
      counter_q <= '0;
      for (int i = 0; i < NH; i++) hist_q[i] <= '0;
      sum_q     <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      iter_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      bpm_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      counter_q <= counter_d;
      for (int i = 0; i < NH; i++) hist_q[i] <= hist_d[i];
      sum_q     <= sum_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      iter_q    <= iter_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      bpm_q     <= bpm_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.bpm_estimate = bpm_q;
  assign bus.bpm_valid    = valid_q;
  assign bus.locked       = locked_q;
  assign bus.busy         = busy_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_bpm_estimator.sv
// Bench for bpm_estimator at CLK_HZ=1000 (intervals 300..1500 cycles): cycle-level tempo model
// plus a literal queue of the estimates each bpm_valid strobe must carry.
module tb_bpm_estimator;
  localparam int CLK_HZ   = 1000;
  localparam int MAX_BPM  = 200;
  localparam int MIN_BPM  = 40;
  localparam int AVG_LOG2 = 2;
  localparam int BW       = 8;
  localparam int K_CONST  = 60000;
  localparam int MIN_INT  = 300;
  localparam int MAX_INT  = 1500;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   ncyc  = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pw = 3;

  logic [BW-1:0] exp_q[$];
  int   first_valid_n = -1;
  logic first_valid_locked = 1'b0;
  int   e1_n = 0;

  bpm_estimator_if #(.BW(BW)) bus();

  bpm_estimator #(
    .CLK_HZ(CLK_HZ), .MAX_BPM(MAX_BPM), .MIN_BPM(MIN_BPM), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock/reset block
  initial forever begin
    #5 clk = 1'b1;
    #5 ncyc++;
    clk = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // behavioural model: cycle stamps of edges and a queue of accepted intervals
  int m_c = 0;
  bit m_run = 0;
  bit m_prev = 0;
  int m_start = 0;
  int m_acc_c = -1000;
  int m_hist[$];
  int m_pending = 0;
  int m_bpm = 0;
  bit m_valid = 0;
  bit m_locked = 0;
  bit m_busy = 0;

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_start = 0; m_acc_c = -1000;
    m_hist.delete();
    m_pending = 0; m_bpm = 0; m_valid = 0; m_locked = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit e;
    int iv, s, q;
    m_c++;
    e = (bus.beat_in === 1'b1) && !m_prev;
    m_prev = (bus.beat_in === 1'b1);
    if (!m_run) begin
      if (e) begin m_run = 1; m_start = m_c; end
    end else if (m_c - m_start == MAX_INT + 1) begin
      m_hist.delete();
      m_locked = 0;
      if (e) m_start = m_c;
      else   m_run = 0;
    end else if (e && (m_c - m_start >= MIN_INT)) begin
      iv = m_c - m_start;
      if (m_hist.size() == 0) begin
        for (int i = 0; i < (1 << AVG_LOG2); i++) m_hist.push_back(iv);
      end else begin
        m_hist.push_front(iv);
        void'(m_hist.pop_back());
      end
      s = 0;
      foreach (m_hist[i]) s += m_hist[i];
      q = K_CONST / (s / (1 << AVG_LOG2));
      if (q < MIN_BPM) q = MIN_BPM;
      if (q > MAX_BPM) q = MAX_BPM;
      m_pending = q;
      m_locked  = 1;
      m_start   = m_c;
      m_acc_c   = m_c;
    end
    m_valid = (m_c == m_acc_c + 33);
    if (m_valid) m_bpm = m_pending;
    m_busy = (m_c >= m_acc_c + 1) && (m_c <= m_acc_c + 32);
  endtask

  initial forever begin
    @(posedge clk);
    if (!reset) model_step();
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    #1;
    if (reset) model_reset();
    check("bpm_estimate", 32'(bus.bpm_estimate), 32'(m_bpm));
    check("bpm_valid",    32'(bus.bpm_valid),    32'(m_valid));
    check("locked",       32'(bus.locked),       32'(m_locked));
    check("busy",         32'(bus.busy),         32'(m_busy));
  end

  // scoreboard: every strobe must match the next literal estimate
  initial forever begin
    @(negedge clk);
    #2;
    if (bus.bpm_valid === 1'b1) begin
      if (first_valid_n < 0) begin
        first_valid_n      = ncyc;
        first_valid_locked = bus.locked;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe actual=bpm_valid with %0d required=no strobe (t=%0t)",
                 bus.bpm_estimate, $time);
      end else begin
        check("strobe_value", 32'(bus.bpm_estimate), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver: n negedges; beat drops after pw, rises on the last one when rise is set
  task automatic run(input int n, input bit rise);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == pw) bus.beat_in = 1'b0;
      if (rise && (i == n)) bus.beat_in = 1'b1;
    end
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(BW'(v));
  endtask

  initial begin
    bus.beat_in = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("reset_bpm",    32'(bus.bpm_estimate), 0);
    check("reset_valid",  32'(bus.bpm_valid),    0);
    check("reset_locked", 32'(bus.locked),       0);
    check("reset_busy",   32'(bus.busy),         0);
    @(negedge clk);
    reset = 1'b0;
    run(5, 0);

    // steady 500-cycle cadence, one beat held high 400 cycles, then 600-cycle cadence
    for (int i = 0; i < 5; i++) push_exp(120);
    push_exp(114); push_exp(109); push_exp(104); push_exp(100); push_exp(100);
    run(1, 1);
    run(250, 0);
    #1 check("locked_before_second_edge", 32'(bus.locked), 0);
    run(250, 1);
    e1_n = ncyc;
    for (int i = 0; i < 3; i++) run(500, 1);
    pw = 400;
    run(500, 1);
    pw = 3;
    for (int i = 0; i < 5; i++) run(600, 1);

    // back to 500 with a spurious edge 150 cycles into one beat
    push_exp(104); push_exp(109); push_exp(114); push_exp(120); push_exp(120);
    for (int i = 0; i < 4; i++) run(500, 1);
    run(150, 1);
    run(350, 1);
    run(40, 0);
    #1 check("bpm_after_debounce", 32'(bus.bpm_estimate), 120);

    // timeout holds the estimate and clears history
    run(1600, 0);
    #1 check("timeout_locked", 32'(bus.locked), 0);
    check("timeout_hold_bpm", 32'(bus.bpm_estimate), 120);
    push_exp(120); push_exp(114);
    run(1, 1);
    run(500, 1);
    run(600, 1);
    run(1600, 0);
    #1 check("timeout_hold_114", 32'(bus.bpm_estimate), 114);
    push_exp(120);
    run(1, 1);
    run(500, 1);
    run(40, 0);
    #1 check("no_carry_over", 32'(bus.bpm_estimate), 120);

    // boundary intervals
    run(1600, 0);
    push_exp(200);
    run(1, 1);
    run(300, 1);
    run(1600, 0);
    #1 check("min_interval_bpm", 32'(bus.bpm_estimate), 200);
    push_exp(40);
    run(1, 1);
    run(1500, 1);
    run(1600, 0);
    #1 check("max_interval_bpm", 32'(bus.bpm_estimate), 40);
    push_exp(120);
    run(1, 1);
    run(299, 1);
    run(201, 1);
    run(1600, 0);
    #1 check("reject_299_bpm", 32'(bus.bpm_estimate), 120);

    // edge coincident with timeout restarts as a first beat
    run(1, 1);
    run(1501, 1);
    push_exp(200);
    run(300, 1);
    run(40, 0);
    #1 check("coincident_timeout_bpm", 32'(bus.bpm_estimate), 200);

    // reset 10 cycles into a division
    run(1600, 0);
    run(1, 1);
    run(500, 1);
    run(12, 0);
    reset = 1'b1;
    #1;
    check("midreset_bpm",    32'(bus.bpm_estimate), 0);
    check("midreset_locked", 32'(bus.locked),       0);
    check("midreset_busy",   32'(bus.busy),         0);
    check("midreset_valid",  32'(bus.bpm_valid),    0);
    run(3, 0);
    reset = 1'b0;
    run(50, 0);
    #1 check("pending_after_reset", exp_q.size(), 0);
    push_exp(200);
    run(1, 1);
    run(300, 1);
    run(40, 0);
    #1 check("first_beat_after_reset", 32'(bus.bpm_estimate), 200);

    check("missing_strobes", exp_q.size(), 0);
    check("first_valid_latency", 32'(first_valid_n - e1_n), 34);
    check("locked_at_first_valid", 32'(first_valid_locked), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
